instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch-side initiator for the processor's combinational instruction memory.
- Owns the program counter and presents it as a byte address on imem_pc; the memory returns the 16-bit instruction in the same cycle.
- Captures {pc, instruction} pairs into a small prefetch buffer and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt, and PC wrap-around.

Parameters:
- DEPTH, 2: prefetch buffer entries; power of two, at least 2.
- RESET_PC, 16'h0000: PC value loaded on reset; bit 0 must be 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_pc  output  16  byte address to instruction memory; always equals the fetch_pc register.
- imem_instruction  input  16  instruction word returned combinationally for imem_pc.
- if_valid  output  1  buffer head holds a valid instruction.
- if_instr  output  16  instruction at the buffer head; 16'h0000 (NOP) when empty.
- if_pc  output  16  PC of if_instr; 16'h0000 when empty.
- id_ready  input  1  decode accepts the head this cycle.
- redirect_valid  input  1  taken branch/jump; flushes the buffer and retargets fetch.
- redirect_pc  input  16  redirect target address.
- halt  input  1  stop fetching new words; the buffer still drains.
- align_err  output  1  sticky flag: a redirect had redirect_pc[0]=1.

Behaviour:
- Reset, taking effect on the edge where rst=1:
  - fetch_pc=RESET_PC, buffer count=0, rd/wr pointers=0.
  - State=RUN, align_err=0, if_valid=0, if_instr=0, if_pc=0.
- Reset has priority over every other input, including mid-redirect and mid-halt.
- Definitions:
  - pop = if_valid & id_ready.
  - push = (state==RUN) & ~redirect_valid & ((count<DEPTH) | pop).
- On push:
  - Write {imem_pc, imem_instruction} at wr_ptr.
  - fetch_pc <= fetch_pc + 2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- If push=0 and redirect_valid=0, fetch_pc holds.
- Pop advances rd_ptr. Simultaneous push and pop leaves count unchanged and is legal when full.
- Count never exceeds DEPTH. When count==0, if_valid=0 and the outputs read NOP/0.
- Outputs are driven from the buffer head (registered storage). Fetch-to-decode latency is 1 cycle: a word captured at edge N is visible on if_valid/if_instr after edge N.
- Redirect (redirect_valid=1):
  - Highest priority after rst.
  - Buffer flushed (count=0, pointers=0); no push that cycle.
  - fetch_pc <= {redirect_pc[15:1],1'b0}.
  - If redirect_pc[0]=1, set align_err=1; it clears only on rst.
  - A pop in the redirect cycle still completes (decode consumed the head), then the flush applies.
  - The target instruction appears on if_valid 2 edges after the redirect edge.
- FSM, two states:
  - RUN: fetch as above. halt=1 moves to HALTED on the next edge; no push in the cycle halt is sampled high.
  - HALTED: no pushes; fetch_pc holds; the buffer drains via pop. halt=0 returns to RUN on the next edge.
  - A redirect in HALTED flushes and updates fetch_pc but stays HALTED.
- Back-to-back redirects: the last one wins; each flushes.
- Never emits a word fetched before a redirect once that redirect edge has passed.

Test Plan:
- Reset, then id_ready=1 and halt=0, with the memory loaded so word at address a = a | 16'h3000 → if_pc sequence 0,2,4,6,… one per cycle from the 2nd edge; imem_pc advances by 2 each cycle.
- id_ready=0 after reset → count reaches 2, imem_pc stalls at 4, if_pc=0; raise id_ready → 0,2,4 in order with no loss or duplication.
- Buffer full (if_pc=0x0010), redirect_valid=1 with redirect_pc=0x0040 for one cycle → if_valid=0 next cycle; 0x0040 is valid 2 edges after the redirect; 0x0010/0x0012 are never seen again.
- Redirect to 0xFFFC with id_ready=1 → if_pc 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- Redirect with redirect_pc=0x0031 → fetch resumes at 0x0030, align_err=1 and stays 1 until rst.
- halt=1 with the buffer full → imem_pc frozen and the buffer drains to if_valid=0. Then assert rst mid-drain → next cycle imem_pc=0, if_valid=0, align_err=0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, prefetches {pc, instruction} pairs into a
// small buffer and hands them to decode over a valid/ready handshake.
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instruction,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        align_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t         state_r;
  logic [15:0]    fetch_pc_r;
  logic [15:0]    pc_mem_r    [DEPTH];
  logic [15:0]    instr_mem_r [DEPTH];
  logic [PW-1:0]  rd_ptr_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [PW:0]    count_r;
  logic           align_err_r;
  logic           valid_s;
  logic           pop_s;
  logic           push_s;

  // A word may be captured in the same cycle it frees a slot, so a full buffer
  // with a consuming decoder still streams one word per cycle.
  assign valid_s = (count_r != {(PW+1){1'b0}});
  assign pop_s   = valid_s & id_ready;
  assign push_s  = (state_r == RUN) & ~halt & ~redirect_valid &
                   ((count_r < DEPTH_C) | pop_s);

  assign imem_pc   = fetch_pc_r;
  assign if_valid  = valid_s;
  assign if_instr  = valid_s ? instr_mem_r[rd_ptr_r] : 16'h0000;
  assign if_pc     = valid_s ? pc_mem_r[rd_ptr_r]    : 16'h0000;
  assign align_err = align_err_r;

  // Fetch state: PC, buffer storage/pointers, run/halt FSM and sticky alignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      fetch_pc_r  <= RESET_PC;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {(PW+1){1'b0}};
      align_err_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 16'h0000;
        instr_mem_r[i] <= 16'h0000;
      end
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
        instr_mem_r[wr_ptr_r] <= imem_instruction;
      end

      if (redirect_valid) begin
        // Flush wins over any pop in the same cycle; the popped head was consumed.
        fetch_pc_r <= {redirect_pc[15:1], 1'b0};
        rd_ptr_r   <= {PW{1'b0}};
        wr_ptr_r   <= {PW{1'b0}};
        count_r    <= {(PW+1){1'b0}};
        if (redirect_pc[0]) begin
          align_err_r <= 1'b1;
        end
      end else begin
        if (push_s) begin
          fetch_pc_r <= fetch_pc_r + 16'd2;
          wr_ptr_r   <= wr_ptr_r + PW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (PW+1)'(1);
          2'b01:   count_r <= count_r - (PW+1)'(1);
          default: count_r <= count_r;
        endcase
      end

      case (state_r)
        RUN:     state_r <= halt ? HALTED : RUN;
        HALTED:  state_r <= halt ? HALTED : RUN;
        default: state_r <= RUN;
      endcase
    end
  end

endmodule
